// File: rtl/ai_i2s_tdm_tx.sv
// ai_i2s_tdm_tx
// Multi-channel I2S / one-bit frame-sync TDM transmitter (master mode).
// Samples arrive on a valid/ready stream in channel order, are buffered in a
// small FIFO and are serialized MSB-first into frames of CHANNELS slots of
// SLOT_WIDTH bits. Bit clock and word select are generated from wb_clk_i.
// A frame that cannot be fully served from the FIFO at its start is sent as
// silence and flagged through the sticky underrun_o.
//
// Ports
//   wb_clk_i        sole clock
//   wb_rst_i        synchronous active-high reset
//   enable_i        run the serializer (low returns to idle, FIFO kept)
//   tdm_mode_i      0 = I2S word select, 1 = one-bit TDM frame sync
//   clk_div_i       SCK half period minus one, in wb_clk_i cycles
//   tx_data_valid   sample valid
//   tx_data         sample
//   tx_data_ready   FIFO can accept a sample
//   fifo_level      FIFO occupancy
//   i2s_sck         bit clock
//   i2s_ws          word select / frame sync
//   i2s_sd_out      serial data
//   frame_start_o   one-cycle pulse at every frame launch
//   underrun_o      sticky underrun flag
//   underrun_clr_i  clears underrun_o (a simultaneous set wins)
module ai_i2s_tdm_tx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int CHANNELS     = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int DIV_WIDTH    = 8
) (
  input  logic                               wb_clk_i,
  input  logic                               wb_rst_i,
  input  logic                               enable_i,
  input  logic                               tdm_mode_i,
  input  logic [DIV_WIDTH-1:0]               clk_div_i,
  input  logic                               tx_data_valid,
  input  logic [SAMPLE_WIDTH-1:0]            tx_data,
  output logic                               tx_data_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               i2s_sck,
  output logic                               i2s_ws,
  output logic                               i2s_sd_out,
  output logic                               frame_start_o,
  output logic                               underrun_o,
  input  logic                               underrun_clr_i
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BIT_W  = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam int SLOT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  CH_L      = LVL_W'(CHANNELS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FIFO_DEPTH - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SLOT_WIDTH - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);
  // One extra bit so SAMPLE_WIDTH == SLOT_WIDTH (e.g. 32) still fits.
  localparam logic [BIT_W:0]    SAMPLE_L  = (BIT_W + 1)'(SAMPLE_WIDTH);

  // ---------------------------------------------------------------------------
  // Sample FIFO. The head is read combinationally so a popped sample can be
  // launched on the serial line in the very cycle it leaves the FIFO.
  // ---------------------------------------------------------------------------
  logic [SAMPLE_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]       wr_ptr_reg;
  logic [ADDR_W-1:0]       rd_ptr_reg;
  logic [LVL_W-1:0]        level_reg;
  logic                    push_en;
  logic                    pop_en;
  logic                    pop_req;
  logic [SAMPLE_WIDTH-1:0] fifo_head;

  // A full FIFO refuses a push even if a pop happens in the same cycle.
  assign push_en   = tx_data_valid && (level_reg < DEPTH_L);
  assign pop_en    = pop_req && (level_reg != '0);
  assign fifo_head = fifo_mem[rd_ptr_reg];

  always_ff @(posedge wb_clk_i) begin
    if (push_en && !wb_rst_i) begin
      fifo_mem[wr_ptr_reg] <= tx_data;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= (wr_ptr_reg == LAST_ADDR) ? '0 : wr_ptr_reg + ADDR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_reg <= (rd_ptr_reg == LAST_ADDR) ? '0 : rd_ptr_reg + ADDR_W'(1);
      end
      case ({push_en, pop_en})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // I2S word-select level per slot: low for the first half of the slots.
  // Sized to the full slot index range so any index is in bounds.
  // ---------------------------------------------------------------------------
  logic [(1 << SLOT_W)-1:0] ws_slot_tbl;

  generate
    for (genvar gi = 0; gi < (1 << SLOT_W); gi++) begin : g_ws_tbl
      assign ws_slot_tbl[gi] = (gi >= CHANNELS / 2);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [DIV_WIDTH-1:0]    div_cnt_reg;
  logic [DIV_WIDTH-1:0]    div_lim_reg;
  logic                    sck_reg;
  logic [BIT_W-1:0]        bit_reg;
  logic [SLOT_W-1:0]       slot_reg;
  logic                    frame_valid_reg;
  logic [SAMPLE_WIDTH-1:0] shift_reg;
  logic                    sd_reg;
  logic                    ws_reg;
  logic                    frame_start_reg;
  logic                    underrun_reg;

  logic              run_active;
  logic              div_wrap;
  logic              start_launch;
  logic              launch;
  logic [BIT_W-1:0]  l_bit;
  logic [SLOT_W-1:0] l_slot;
  logic [SLOT_W-1:0] q_slot;
  logic              q_first;
  logic              frame_begin;
  logic              level_ok;
  logic              frame_ok;
  logic              slot_load;
  logic              ws_launch;
  logic              sd_launch;

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (enable_i)  state_next = ST_RUN;
      ST_RUN:  if (!enable_i) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    run_active   = (state_reg == ST_RUN) && enable_i;
    div_wrap     = run_active && (div_cnt_reg == div_lim_reg);
    // Leaving idle launches position 0 immediately; afterwards every falling
    // SCK toggle launches the next position.
    start_launch = (state_reg == ST_IDLE) && enable_i;
    launch       = start_launch || (div_wrap && sck_reg);

    // Position being launched this cycle.
    l_bit  = '0;
    l_slot = '0;
    if (!start_launch) begin
      if (bit_reg == LAST_BIT) begin
        l_bit  = '0;
        l_slot = (slot_reg == LAST_SLOT) ? '0 : slot_reg + SLOT_W'(1);
      end else begin
        l_bit  = bit_reg + BIT_W'(1);
        l_slot = slot_reg;
      end
    end

    // WS runs one bit ahead, so it is derived from the position after l.
    q_slot  = l_slot;
    q_first = 1'b0;
    if (l_bit == LAST_BIT) begin
      q_slot  = (l_slot == LAST_SLOT) ? '0 : l_slot + SLOT_W'(1);
      q_first = (l_slot == LAST_SLOT);
    end
    ws_launch = tdm_mode_i ? q_first : ws_slot_tbl[q_slot];

    // The frame is served only if every slot's sample is already queued.
    frame_begin = launch && (l_bit == '0) && (l_slot == '0);
    level_ok    = (level_reg >= CH_L);
    frame_ok    = frame_begin ? level_ok : frame_valid_reg;
    slot_load   = launch && (l_bit == '0) && frame_ok;
    pop_req     = slot_load;

    sd_launch = 1'b0;
    if (slot_load) begin
      sd_launch = fifo_head[SAMPLE_WIDTH-1];
    end else if (frame_ok && ({1'b0, l_bit} < SAMPLE_L)) begin
      sd_launch = shift_reg[SAMPLE_WIDTH-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Divider, frame position and serializer registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      div_cnt_reg     <= '0;
      div_lim_reg     <= '0;
      sck_reg         <= 1'b0;
      bit_reg         <= '0;
      slot_reg        <= '0;
      frame_valid_reg <= 1'b0;
      shift_reg       <= '0;
      sd_reg          <= 1'b0;
      ws_reg          <= 1'b0;
      frame_start_reg <= 1'b0;
    end else if (!enable_i) begin
      // Idle, or abort of a running frame: outputs quiet, position cleared.
      div_cnt_reg     <= '0;
      div_lim_reg     <= clk_div_i;
      sck_reg         <= 1'b0;
      bit_reg         <= '0;
      slot_reg        <= '0;
      frame_valid_reg <= 1'b0;
      shift_reg       <= '0;
      sd_reg          <= 1'b0;
      ws_reg          <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= frame_begin;

      // The divisor is sampled at each wrap so a change applies to the next
      // half period instead of truncating the current one.
      if (start_launch) begin
        div_cnt_reg <= '0;
        sck_reg     <= 1'b0;
        div_lim_reg <= clk_div_i;
      end else if (div_wrap) begin
        div_cnt_reg <= '0;
        sck_reg     <= ~sck_reg;
        div_lim_reg <= clk_div_i;
      end else begin
        div_cnt_reg <= div_cnt_reg + DIV_WIDTH'(1);
      end

      if (launch) begin
        bit_reg  <= l_bit;
        slot_reg <= l_slot;
        sd_reg   <= sd_launch;
        ws_reg   <= ws_launch;
        if (frame_begin) begin
          frame_valid_reg <= level_ok;
        end
        if (slot_load) begin
          shift_reg <= fifo_head << 1;
        end else if (frame_ok) begin
          shift_reg <= shift_reg << 1;
        end else begin
          shift_reg <= '0;
        end
      end
    end
  end

  // Sticky underrun: a new underrun beats a simultaneous clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      underrun_reg <= 1'b0;
    end else if (frame_begin && !level_ok) begin
      underrun_reg <= 1'b1;
    end else if (underrun_clr_i) begin
      underrun_reg <= 1'b0;
    end
  end

  assign tx_data_ready = (level_reg < DEPTH_L);
  assign fifo_level    = level_reg;
  assign i2s_sck       = sck_reg;
  assign i2s_ws        = ws_reg;
  assign i2s_sd_out    = sd_reg;
  assign frame_start_o = frame_start_reg;
  assign underrun_o    = underrun_reg;

endmodule
